round_sched: RTL and testbench
==============================

ROUND_SCHED -- requirements
Module: round_sched

Interface
REQ-001 SHALL have parameter N_PLAYERS, default 2, number of players taking turns (1..4).
REQ-002 SHALL have parameter ROUNDS, default 3, turns per player per match (1..5).
REQ-003 SHALL have parameter HOLD_CNT, default 100000000, cycles a core result is shown before acknowledge (2 s at 50 MHz).
REQ-004 SHALL have parameter DB_CNT, default 1000000, debounce stable-count in cycles (20 ms).
REQ-005 CLK  in  1  50 MHz clock; all logic on posedge.
REQ-006 RST_N  in  1  reset, synchronous, active-low.
REQ-007 KEY_GO  in  1  active-low match-start button, asynchronous.
REQ-008 KEY_P  in  4  active-low per-player stop buttons, asynchronous; bit i = player i.
REQ-009 CORE_STATE  in  2  timing-core state: 0 input wait, 1 countdown, 2 measure, 3 result.
REQ-010 CORE_RESULT  in  2  core judgement: 0 just, 1 +/-0.1 s, 2 +/-0.2 s, 3 bad.
REQ-011 CORE_START_N  out  1  active-low start request to core.
REQ-012 CORE_STOP_N  out  1  active-low stop/acknowledge to core.
REQ-013 PLAYER  out  2  current player index.
REQ-014 ROUND  out  3  current round, 1-based.
REQ-015 SCORES  out  16  {p3,p2,p1,p0}, 4 bits each.
REQ-016 DONE  out  1  match finished; WINNER  out  2  winning player index, valid while DONE=1.

Function
REQ-017 Key inputs SHALL pass a 2-flop synchronizer; a "press" is a synchronized 1->0 edge.
REQ-018 FSM states SHALL be IDLE, ARM, RUN, JUDGE, HOLD, ACK, NEXT, FIN.
REQ-019 IDLE/FIN: KEY_GO press SHALL clear SCORES, set PLAYER=0, ROUND=1, DONE=0, go ARM next cycle.
REQ-020 ARM: CORE_START_N SHALL be 0 until CORE_STATE!=0 is sampled, then 1 and go RUN.
REQ-021 RUN: CORE_STOP_N SHALL equal synchronized KEY_P[PLAYER] only while CORE_STATE==2, else 1; other players' keys ignored.
REQ-022 RUN: CORE_STATE==3 sampled SHALL go JUDGE.
REQ-023 JUDGE (one cycle): SCORES[PLAYER] += 3,2,1,0 for CORE_RESULT 0,1,2,3; go HOLD.
REQ-024 HOLD: count HOLD_CNT cycles, then ACK; counter cleared on entry.
REQ-025 ACK: CORE_STOP_N SHALL be 0 until CORE_STATE==0 sampled, then 1 and go NEXT.
REQ-026 NEXT (one cycle): if PLAYER<N_PLAYERS-1, PLAYER++; else PLAYER=0 and ROUND++; if last player of ROUND==ROUNDS, go FIN instead, else ARM.
REQ-027 FIN: DONE=1; WINNER = highest score, ties to lowest index; PLAYER/ROUND/SCORES hold.
REQ-028 KEY_GO SHALL be ignored outside IDLE and FIN.
REQ-029 CORE_START_N and CORE_STOP_N SHALL never be 0 in the same cycle.
REQ-030 Score arithmetic SHALL not wrap: max 5x3=15 fits 4 bits; SCORES for players >= N_PLAYERS stay 0.
REQ-031 CORE_STATE returning to 0 during RUN/JUDGE/HOLD (external reset of core) SHALL abandon the turn, no score, go ARM for same player/round.

Reset
REQ-032 RST_N=0 at any state SHALL on next edge force IDLE, CORE_START_N=1, CORE_STOP_N=1, PLAYER=0, ROUND=1, SCORES=0, DONE=0, WINNER=0, all counters and sync/debounce flops cleared (keys read as released).
REQ-033 Reset mid-match SHALL discard the match; no press is generated by keys already held at reset release.

Configuration
REQ-034 With macro ROUND_SCHED_DEBOUNCE_EN defined, each synchronized key SHALL change its filtered value only after DB_CNT consecutive equal samples; press latency = DB_CNT+2 cycles.
REQ-035 Without ROUND_SCHED_DEBOUNCE_EN, filtered key = synchronized key, press latency 2 cycles, DB_CNT unused.

Verification (HOLD_CNT=4, DB_CNT=3, N_PLAYERS=2, ROUNDS=2, core model)
REQ-036 Full match, results p0:0,3 p1:1,1 -> SCORES[7:0]=0x43, DONE=1, WINNER=1.
REQ-037 Tie, results all 2 -> SCORES[7:0]=0x22, WINNER=0.
REQ-038 KEY_P[1] pressed during p0 measure -> CORE_STOP_N stays 1; KEY_P[0] during countdown -> ignored.
REQ-039 RST_N low during HOLD of round 2 -> next cycle IDLE, all outputs at reset values, CORE_*_N=1.
REQ-040 Debounce on: 2-cycle glitch on KEY_P[0] -> no stop; 6-cycle low -> CORE_STOP_N=0 after 5 cycles; off: same glitch forwarded.
REQ-041 KEY_GO during RUN -> no state change; core drops to 0 in HOLD -> same player re-armed, score unchanged.

Source files
------------

// File: rtl/round_sched.sv
// Turn scheduler for a multi-player reaction-timing game driving an external timing core.
// Define ROUND_SCHED_DEBOUNCE_EN to insert a DB_CNT-cycle debounce filter after the key synchronizers.
module round_sched #(
  parameter int N_PLAYERS = 2,
  parameter int ROUNDS    = 3,
  parameter int HOLD_CNT  = 100000000,
  parameter int DB_CNT    = 1000000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        KEY_GO,
  input  logic [3:0]  KEY_P,
  input  logic [1:0]  CORE_STATE,
  input  logic [1:0]  CORE_RESULT,
  output logic        CORE_START_N,
  output logic        CORE_STOP_N,
  output logic [1:0]  PLAYER,
  output logic [2:0]  ROUND,
  output logic [15:0] SCORES,
  output logic        DONE,
  output logic [1:0]  WINNER
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0, S_ARM  = 3'd1, S_RUN  = 3'd2, S_JUDGE = 3'd3,
    S_HOLD  = 3'd4, S_ACK  = 3'd5, S_NEXT = 3'd6, S_FIN   = 3'd7
  } state_t;

  localparam int HCW = $clog2(HOLD_CNT + 1);

  logic [4:0] key_raw_s, sync1_q, sync2_q, key_filt_s, prev_q, press_s;
  logic [2:0] vld_q;

  assign key_raw_s = {KEY_GO, KEY_P};

  // vld_q marks when the pipeline holds real samples, so keys held across reset never yield a press
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1_q <= 5'h1F;
      sync2_q <= 5'h1F;
      vld_q   <= 3'b000;
      prev_q  <= 5'h00;
    end else begin
      sync1_q <= key_raw_s;
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[1:0], 1'b1};
      prev_q  <= vld_q[2] ? key_filt_s : 5'h00;
    end
  end

`ifdef ROUND_SCHED_DEBOUNCE_EN
  localparam int DBW = $clog2(DB_CNT + 1);
  logic [4:0]     filt_q;
  logic [DBW-1:0] db_cnt_q [5];

  // Filtered value follows the synchronized key only after DB_CNT consecutive differing samples
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      filt_q <= 5'h1F;
      for (int k = 0; k < 5; k++) db_cnt_q[k] <= {DBW{1'b0}};
    end else if (!vld_q[2]) begin
      filt_q <= sync2_q;
      for (int k = 0; k < 5; k++) db_cnt_q[k] <= {DBW{1'b0}};
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (sync2_q[k] == filt_q[k]) begin
          db_cnt_q[k] <= {DBW{1'b0}};
        end else if (db_cnt_q[k] == DBW'(DB_CNT - 1)) begin
          filt_q[k]   <= sync2_q[k];
          db_cnt_q[k] <= {DBW{1'b0}};
        end else begin
          db_cnt_q[k] <= db_cnt_q[k] + DBW'(1);
        end
      end
    end
  end
  assign key_filt_s = filt_q;
`else
  assign key_filt_s = sync2_q;
`endif

  assign press_s = prev_q & ~key_filt_s;

  state_t         state_q, state_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]     player_q, player_d, winner_q, winner_d, best_s;
  logic [2:0]     round_q, round_d;
  logic [15:0]    scores_q, scores_d;
  logic           done_q, done_d, start_n_q, start_n_d, stop_n_q, stop_n_d;
  logic           last_player_s, last_turn_s;
  logic [3:0]     cur_score_s, best_score_s;
  logic [4:0]     sum_s;

  assign last_player_s = (player_q == 2'(N_PLAYERS - 1));
  assign last_turn_s   = last_player_s && (round_q == 3'(ROUNDS));
  assign cur_score_s   = scores_q[{player_q, 2'b00} +: 4];
  assign sum_s         = {1'b0, cur_score_s} + {3'b000, 2'd3 - CORE_RESULT};

  // Highest score wins; strict compare keeps ties on the lowest index
  always_comb begin
    best_s       = 2'd0;
    best_score_s = scores_q[3:0];
    for (int p = 1; p < N_PLAYERS; p++) begin
      best_s       = (scores_q[p*4 +: 4] > best_score_s) ? 2'(p) : best_s;
      best_score_s = (scores_q[p*4 +: 4] > best_score_s) ? scores_q[p*4 +: 4] : best_score_s;
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a core falling back to idle mid-turn re-arms the same turn
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_FIN: state_d = press_s[4] ? S_ARM : state_q;
      S_ARM:         state_d = (CORE_STATE != 2'd0) ? S_RUN : S_ARM;
      S_RUN: begin
        if (CORE_STATE == 2'd0)      state_d = S_ARM;
        else if (CORE_STATE == 2'd3) state_d = S_JUDGE;
        else                         state_d = S_RUN;
      end
      S_JUDGE:       state_d = (CORE_STATE == 2'd0) ? S_ARM : S_HOLD;
      S_HOLD: begin
        if (CORE_STATE == 2'd0)                      state_d = S_ARM;
        else if (hold_cnt_q == HCW'(HOLD_CNT - 1))   state_d = S_ACK;
        else                                         state_d = S_HOLD;
      end
      S_ACK:         state_d = (CORE_STATE == 2'd0) ? S_NEXT : S_ACK;
      S_NEXT:        state_d = last_turn_s ? S_FIN : S_ARM;
      default:       state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; strobes derive from state_d so registered outputs align with state
  always_comb begin
    player_d   = player_q;
    round_d    = round_q;
    scores_d   = scores_q;
    done_d     = done_q;
    winner_d   = winner_q;
    hold_cnt_d = (state_q == S_HOLD) ? hold_cnt_q + HCW'(1) : {HCW{1'b0}};
    start_n_d  = (state_d != S_ARM);
    if (state_d == S_ACK)                              stop_n_d = 1'b0;
    else if (state_d == S_RUN && CORE_STATE == 2'd2)   stop_n_d = key_filt_s[player_q];
    else                                               stop_n_d = 1'b1;
    case (state_q)
      S_IDLE, S_FIN: begin
        if (press_s[4]) begin
          scores_d = 16'h0000;
          player_d = 2'd0;
          round_d  = 3'd1;
          done_d   = 1'b0;
          winner_d = 2'd0;
        end else begin
          done_d = done_q;
        end
      end
      S_JUDGE: begin
        if (state_d == S_HOLD) scores_d[{player_q, 2'b00} +: 4] = (sum_s > 5'd15) ? 4'hF : sum_s[3:0];
        else                   scores_d = scores_q;
      end
      S_NEXT: begin
        if (last_turn_s) begin
          done_d   = 1'b1;
          winner_d = best_s;
        end else if (last_player_s) begin
          player_d = 2'd0;
          round_d  = round_q + 3'd1;
        end else begin
          player_d = player_q + 2'd1;
        end
      end
      default: begin
        done_d = done_q;
      end
    endcase
  end

  // Registered outputs and hold counter
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      player_q   <= 2'd0;
      round_q    <= 3'd1;
      scores_q   <= 16'h0000;
      done_q     <= 1'b0;
      winner_q   <= 2'd0;
      hold_cnt_q <= {HCW{1'b0}};
      start_n_q  <= 1'b1;
      stop_n_q   <= 1'b1;
    end else begin
      player_q   <= player_d;
      round_q    <= round_d;
      scores_q   <= scores_d;
      done_q     <= done_d;
      winner_q   <= winner_d;
      hold_cnt_q <= hold_cnt_d;
      start_n_q  <= start_n_d;
      stop_n_q   <= stop_n_d;
    end
  end

  assign CORE_START_N = start_n_q;
  assign CORE_STOP_N  = stop_n_q;
  assign PLAYER       = player_q;
  assign ROUND        = round_q;
  assign SCORES       = scores_q;
  assign DONE         = done_q;
  assign WINNER       = winner_q;

endmodule

// File: tb/tb_round_sched.sv
// Directed bench for round_sched with a small behavioural timing-core model.
module tb_round_sched;

  logic        CLK = 1'b0;
  logic        RST_N, KEY_GO;
  logic [3:0]  KEY_P;
  logic [1:0]  cs, core_res;
  logic        CORE_START_N, CORE_STOP_N;
  logic [1:0]  PLAYER, WINNER;
  logic [2:0]  ROUND;
  logic [15:0] SCORES;
  logic        DONE;
  logic [4:0]  cd;
  logic        seen_hi, core_kill;
  int          n_cmp = 0, n_err = 0, both_low = 0;

  always #5 CLK = ~CLK;

  round_sched #(.N_PLAYERS(2), .ROUNDS(2), .HOLD_CNT(4), .DB_CNT(3)) dut (
    .CLK(CLK), .RST_N(RST_N), .KEY_GO(KEY_GO), .KEY_P(KEY_P),
    .CORE_STATE(cs), .CORE_RESULT(core_res),
    .CORE_START_N(CORE_START_N), .CORE_STOP_N(CORE_STOP_N),
    .PLAYER(PLAYER), .ROUND(ROUND), .SCORES(SCORES), .DONE(DONE), .WINNER(WINNER)
  );

  // Core model: start -> 20-cycle countdown -> measure until stop -> result until a fresh stop pulse
  always @(posedge CLK) begin
    if (!RST_N || core_kill) begin
      cs <= 2'd0; cd <= 5'd0; seen_hi <= 1'b0;
    end else begin
      case (cs)
        2'd0: if (!CORE_START_N) begin cs <= 2'd1; cd <= 5'd0; end
        2'd1: if (cd == 5'd19) cs <= 2'd2; else cd <= cd + 5'd1;
        2'd2: if (!CORE_STOP_N) begin cs <= 2'd3; seen_hi <= 1'b0; end
        default: begin
          if (CORE_STOP_N) seen_hi <= 1'b1;
          else if (seen_hi) cs <= 2'd0;
        end
      endcase
    end
  end

  always @(negedge CLK) if (RST_N === 1'b1 && CORE_START_N === 1'b0 && CORE_STOP_N === 1'b0) both_low++;

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_cs(input logic [1:0] v);
    int k;
    k = 0;
    while (cs !== v && k < 300) begin tick(1); k++; end
    n_cmp++;
    if (cs !== v) begin n_err++; $display("FAIL wait_core_state: got %0d want %0d after %0d cycles", cs, v, k); end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (DONE !== 1'b1 && k < 300) begin tick(1); k++; end
    n_cmp++;
    if (DONE !== 1'b1) begin n_err++; $display("FAIL wait_done: DONE=%b want 1", DONE); end
  endtask

  task automatic press_go();
    KEY_GO = 1'b0; tick(6); KEY_GO = 1'b1; tick(2);
  endtask

  task automatic play_turn(input int p, input logic [1:0] res);
    core_res = res;
    wait_cs(2'd2);
    KEY_P[p] = 1'b0; tick(6); KEY_P[p] = 1'b1;
    wait_cs(2'd3);
    wait_cs(2'd0);
    tick(3);
  endtask

  task automatic do_reset();
    RST_N = 1'b0; tick(3); RST_N = 1'b1; tick(2);
  endtask

  task automatic test_reset();
    RST_N = 1'b0; KEY_GO = 1'b1; KEY_P = 4'hF; core_kill = 1'b0; core_res = 2'd0;
    tick(3);
    n_cmp++; if (CORE_START_N !== 1'b1) begin n_err++; $display("FAIL rst_start_n: got %b want 1", CORE_START_N); end
    n_cmp++; if (CORE_STOP_N !== 1'b1)  begin n_err++; $display("FAIL rst_stop_n: got %b want 1", CORE_STOP_N); end
    n_cmp++; if (PLAYER !== 2'd0)       begin n_err++; $display("FAIL rst_player: got %0d want 0", PLAYER); end
    n_cmp++; if (ROUND !== 3'd1)        begin n_err++; $display("FAIL rst_round: got %0d want 1", ROUND); end
    n_cmp++; if (SCORES !== 16'h0000)   begin n_err++; $display("FAIL rst_scores: got %h want 0000", SCORES); end
    n_cmp++; if (DONE !== 1'b0)         begin n_err++; $display("FAIL rst_done: got %b want 0", DONE); end
    n_cmp++; if (WINNER !== 2'd0)       begin n_err++; $display("FAIL rst_winner: got %0d want 0", WINNER); end
    RST_N = 1'b1; tick(4);
    n_cmp++; if (CORE_START_N !== 1'b1) begin n_err++; $display("FAIL idle_no_start: got %b want 1", CORE_START_N); end
  endtask

  task automatic test_full_match();
    press_go();
    n_cmp++; if (ROUND !== 3'd1 || PLAYER !== 2'd0) begin n_err++; $display("FAIL go_init: round %0d player %0d want 1/0", ROUND, PLAYER); end
    play_turn(0, 2'd0);
    n_cmp++; if (SCORES !== 16'h0003) begin n_err++; $display("FAIL turn1_scores: got %h want 0003", SCORES); end
    n_cmp++; if (PLAYER !== 2'd1)     begin n_err++; $display("FAIL turn1_player: got %0d want 1", PLAYER); end
    play_turn(1, 2'd1);
    n_cmp++; if (SCORES !== 16'h0023) begin n_err++; $display("FAIL turn2_scores: got %h want 0023", SCORES); end
    n_cmp++; if (PLAYER !== 2'd0 || ROUND !== 3'd2) begin n_err++; $display("FAIL turn2_wrap: player %0d round %0d want 0/2", PLAYER, ROUND); end
    play_turn(0, 2'd3);
    play_turn(1, 2'd1);
    wait_done();
    n_cmp++; if (SCORES !== 16'h0043) begin n_err++; $display("FAIL match_scores: got %h want 0043", SCORES); end
    n_cmp++; if (WINNER !== 2'd1)     begin n_err++; $display("FAIL match_winner: got %0d want 1", WINNER); end
    n_cmp++; if (both_low !== 0)      begin n_err++; $display("FAIL strobe_overlap: got %0d cycles want 0", both_low); end
  endtask

  task automatic test_tie();
    press_go();
    n_cmp++; if (SCORES !== 16'h0000 || DONE !== 1'b0) begin n_err++; $display("FAIL restart_clear: scores %h done %b want 0000/0", SCORES, DONE); end
    play_turn(0, 2'd2);
    play_turn(1, 2'd2);
    play_turn(0, 2'd2);
    play_turn(1, 2'd2);
    wait_done();
    n_cmp++; if (SCORES !== 16'h0022) begin n_err++; $display("FAIL tie_scores: got %h want 0022", SCORES); end
    n_cmp++; if (WINNER !== 2'd0)     begin n_err++; $display("FAIL tie_winner: got %0d want 0", WINNER); end
  endtask

  task automatic test_key_isolation();
    int lows;
    press_go();
    core_res = 2'd0;
    wait_cs(2'd1);
    lows = 0;
    KEY_P[0] = 1'b0;
    for (int i = 1; i <= 12; i++) begin tick(1); if (i == 6) KEY_P[0] = 1'b1; if (CORE_STOP_N === 1'b0) lows++; end
    n_cmp++; if (lows !== 0 || cs !== 2'd1) begin n_err++; $display("FAIL countdown_key: stop lows %0d state %0d want 0/1", lows, cs); end
    wait_cs(2'd2);
    lows = 0;
    KEY_P[1] = 1'b0;
    for (int i = 1; i <= 12; i++) begin tick(1); if (i == 6) KEY_P[1] = 1'b1; if (CORE_STOP_N === 1'b0) lows++; end
    n_cmp++; if (lows !== 0 || cs !== 2'd2) begin n_err++; $display("FAIL other_player_key: stop lows %0d state %0d want 0/2", lows, cs); end
    KEY_GO = 1'b0; tick(6); KEY_GO = 1'b1; tick(6);
    n_cmp++; if (cs !== 2'd2 || PLAYER !== 2'd0 || ROUND !== 3'd1 || CORE_START_N !== 1'b1) begin
      n_err++; $display("FAIL go_in_run: state %0d player %0d round %0d start_n %b want 2/0/1/1", cs, PLAYER, ROUND, CORE_START_N);
    end
    KEY_P[0] = 1'b0; tick(6); KEY_P[0] = 1'b1;
    for (int k = 0; k < 100 && SCORES[3:0] !== 4'd3; k++) tick(1);
    n_cmp++; if (SCORES !== 16'h0003) begin n_err++; $display("FAIL judge_before_kill: got %h want 0003", SCORES); end
    core_kill = 1'b1; tick(1); core_kill = 1'b0;
    for (int k = 0; k < 10 && CORE_START_N !== 1'b0; k++) tick(1);
    n_cmp++; if (CORE_START_N !== 1'b0) begin n_err++; $display("FAIL rearm_after_kill: start_n %b want 0", CORE_START_N); end
    n_cmp++; if (PLAYER !== 2'd0 || ROUND !== 3'd1 || SCORES !== 16'h0003) begin
      n_err++; $display("FAIL rearm_same_turn: player %0d round %0d scores %h want 0/1/0003", PLAYER, ROUND, SCORES);
    end
  endtask

  task automatic test_reset_mid();
    int lows;
    do_reset();
    press_go();
    play_turn(0, 2'd1);
    play_turn(1, 2'd1);
    core_res = 2'd1;
    wait_cs(2'd2);
    KEY_P[0] = 1'b0; tick(6); KEY_P[0] = 1'b1;
    for (int k = 0; k < 100 && SCORES[3:0] !== 4'd4; k++) tick(1);
    n_cmp++; if (SCORES !== 16'h0024 || ROUND !== 3'd2) begin n_err++; $display("FAIL pre_reset: scores %h round %0d want 0024/2", SCORES, ROUND); end
    KEY_GO = 1'b0;
    RST_N = 1'b0; tick(1);
    n_cmp++; if (CORE_START_N !== 1'b1 || CORE_STOP_N !== 1'b1 || PLAYER !== 2'd0 || ROUND !== 3'd1 ||
                 SCORES !== 16'h0000 || DONE !== 1'b0 || WINNER !== 2'd0) begin
      n_err++; $display("FAIL mid_reset: start %b stop %b player %0d round %0d scores %h done %b winner %0d want 1 1 0 1 0000 0 0",
                        CORE_START_N, CORE_STOP_N, PLAYER, ROUND, SCORES, DONE, WINNER);
    end
    RST_N = 1'b1;
    lows = 0;
    for (int i = 0; i < 12; i++) begin tick(1); if (CORE_START_N === 1'b0) lows++; end
    n_cmp++; if (lows !== 0) begin n_err++; $display("FAIL held_go_after_reset: start lows %0d want 0", lows); end
    KEY_GO = 1'b1; tick(8);
    press_go();
    wait_cs(2'd1);
  endtask

  task automatic test_debounce();
    int lows, first;
    do_reset();
    press_go();
    core_res = 2'd0;
    wait_cs(2'd2);
    lows = 0;
    KEY_P[0] = 1'b0;
    for (int i = 1; i <= 12; i++) begin tick(1); if (i == 2) KEY_P[0] = 1'b1; if (CORE_STOP_N === 1'b0) lows++; end
`ifdef ROUND_SCHED_DEBOUNCE_EN
    n_cmp++; if (lows !== 0 || cs !== 2'd2) begin n_err++; $display("FAIL glitch_filtered: stop lows %0d state %0d want 0/2", lows, cs); end
    first = -1;
    KEY_P[0] = 1'b0;
    for (int i = 1; i <= 10; i++) begin tick(1); if (i == 6) KEY_P[0] = 1'b1; if (CORE_STOP_N === 1'b0 && first < 0) first = i; end
    n_cmp++; if (first < 5 || first > 6) begin n_err++; $display("FAIL debounced_stop: first low at %0d want 5..6", first); end
    wait_cs(2'd3);
`else
    n_cmp++; if (lows == 0) begin n_err++; $display("FAIL glitch_forwarded: stop lows %0d want >0", lows); end
`endif
  endtask

  initial begin
    test_reset();
    test_full_match();
    test_tie();
    test_key_isolation();
    test_reset_mid();
    test_debounce();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
